// File: rtl/avl_bus_n21_burst.sv
// -----------------------------------------------------------------------------
// avl_bus_n21_burst
//   N-to-1 Avalon-style interconnect. Arbitrates MASTER_NUM masters onto one
//   slave port with fixed-priority or round-robin selection. The grant is held
//   across write bursts. Read bursts are routed back to the issuing master
//   through a tracking FIFO of {master id, beat count}. Read data passes
//   through a registered response buffer that applies backpressure.
//
// Ports
//   clk, rest                      clock, asynchronous active-low reset
//   in_*  (packed, master i at i)  per-master command inputs
//   in_request_ready               command/beat accepted, one-hot to grantee
//   in_read_data/_valid            buffered read data, valid one-hot to owner
//   in_resp_ready                  per-master read-data acceptance
//   out_*                          command and response port to the slave
// -----------------------------------------------------------------------------
module avl_bus_n21_burst #(
    parameter int MASTER_NUM      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_WIDTH     = 4,
    parameter int ARB_METHOD      = 1,
    parameter int SEL_FIFO_DEPTH  = 8,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rest,
    input  logic [MASTER_NUM*ADDR_WIDTH-1:0]    in_address,
    input  logic [MASTER_NUM*DATA_WIDTH/8-1:0]  in_byte_en,
    input  logic [MASTER_NUM-1:0]               in_read,
    input  logic [MASTER_NUM-1:0]               in_write,
    input  logic [MASTER_NUM*DATA_WIDTH-1:0]    in_write_data,
    input  logic [MASTER_NUM-1:0]               in_begin_burst_transfer,
    input  logic [MASTER_NUM*BURST_WIDTH-1:0]   in_burst_count,
    output logic [MASTER_NUM-1:0]               in_request_ready,
    output logic [DATA_WIDTH-1:0]               in_read_data,
    output logic [MASTER_NUM-1:0]               in_read_data_valid,
    input  logic [MASTER_NUM-1:0]               in_resp_ready,
    output logic [ADDR_WIDTH-1:0]               out_address,
    output logic [DATA_WIDTH/8-1:0]             out_byte_en,
    output logic                                out_read,
    output logic                                out_write,
    output logic [DATA_WIDTH-1:0]               out_write_data,
    output logic                                out_begin_burst_transfer,
    output logic [BURST_WIDTH-1:0]              out_burst_count,
    input  logic                                out_request_ready,
    input  logic [DATA_WIDTH-1:0]               out_read_data,
    input  logic                                out_read_data_valid,
    output logic                                out_resp_ready
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int ID_WIDTH = $clog2(MASTER_NUM);
    localparam int SEL_AW   = $clog2(SEL_FIFO_DEPTH);
    localparam int RESP_AW  = $clog2(RESP_FIFO_DEPTH);

    typedef struct packed {
        logic                   read;
        logic                   write;
        logic                   begin_burst;
        logic [BURST_WIDTH-1:0] burst;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [BE_WIDTH-1:0]    byte_en;
        logic [DATA_WIDTH-1:0]  wdata;
    } cmd_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [BURST_WIDTH-1:0] beats;
    } sel_entry_t;

    // grant_q doubles as the round-robin pointer: it always holds the last granted index
    logic [ID_WIDTH-1:0]    grant_q, grant_d, winner;
    logic                   lock_q, lock_d;
    logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
    logic [BURST_WIDTH-1:0] beat_cnt_q;

    sel_entry_t             sel_mem_q [SEL_FIFO_DEPTH];
    logic [SEL_AW:0]        sel_wr_q, sel_rd_q;
    logic [DATA_WIDTH-1:0]  resp_mem_q [RESP_FIFO_DEPTH];
    logic [RESP_AW:0]       resp_wr_q, resp_rd_q;

    cmd_t                   cmd_arr [MASTER_NUM];
    cmd_t                   cmd;
    sel_entry_t             sel_head, sel_new;
    logic [MASTER_NUM-1:0]  request;
    logic                   accept, grant_update;
    logic                   sel_full, sel_empty, sel_push, sel_pop;
    logic                   resp_full, resp_empty, resp_push, resp_pop;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < MASTER_NUM; i++) begin
            cmd_arr[i].read        = in_read[i];
            cmd_arr[i].write       = in_write[i];
            cmd_arr[i].begin_burst = in_begin_burst_transfer[i];
            cmd_arr[i].burst       = in_burst_count[i*BURST_WIDTH +: BURST_WIDTH];
            cmd_arr[i].addr        = in_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            cmd_arr[i].byte_en     = in_byte_en[i*BE_WIDTH +: BE_WIDTH];
            cmd_arr[i].wdata       = in_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign cmd     = cmd_arr[grant_q];
    assign request = in_read | in_write;

    assign sel_empty  = (sel_wr_q == sel_rd_q);
    assign sel_full   = (sel_wr_q[SEL_AW] != sel_rd_q[SEL_AW]) &&
                        (sel_wr_q[SEL_AW-1:0] == sel_rd_q[SEL_AW-1:0]);
    assign resp_empty = (resp_wr_q == resp_rd_q);
    assign resp_full  = (resp_wr_q[RESP_AW] != resp_rd_q[RESP_AW]) &&
                        (resp_wr_q[RESP_AW-1:0] == resp_rd_q[RESP_AW-1:0]);

    // Command fields are forced low while reset is asserted.
    assign out_read                 = rest && cmd.read && !sel_full;
    assign out_write                = rest && cmd.write;
    assign out_begin_burst_transfer = rest && cmd.begin_burst;
    assign out_burst_count          = rest ? cmd.burst   : '0;
    assign out_address              = rest ? cmd.addr    : '0;
    assign out_byte_en              = rest ? cmd.byte_en : '0;
    assign out_write_data           = rest ? cmd.wdata   : '0;

    assign accept = out_request_ready && (out_read || out_write);

    always_comb begin
        in_request_ready          = '0;
        in_request_ready[grant_q] = rest && out_request_ready && (cmd.write || !sel_full);
    end

    // Arbitration: later loop iterations override earlier ones, so the
    // descending scan leaves the lowest qualifying index as the winner.
    always_comb begin
        winner = grant_q;
        if (ARB_METHOD == 0) begin
            for (int i = MASTER_NUM - 1; i >= 0; i--)
                if (request[i]) winner = ID_WIDTH'(i);
        end else begin
            // wrap-around candidates (at or below the last grant) first,
            // then those above it, which take precedence
            for (int i = MASTER_NUM - 1; i >= 0; i--)
                if (request[i] && i <= int'(grant_q)) winner = ID_WIDTH'(i);
            for (int i = MASTER_NUM - 1; i >= 0; i--)
                if (request[i] && i > int'(grant_q)) winner = ID_WIDTH'(i);
        end
    end

    // Write-burst lock. The next-state lock gates re-arbitration, so the first
    // beat of a burst cannot hand the bus away, and the last beat can.
    always_comb begin
        lock_d      = lock_q;
        remaining_d = remaining_q;
        if (accept && out_write) begin
            if (lock_q) begin
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == BURST_WIDTH'(1)) lock_d = 1'b0;
            end else if (cmd.begin_burst && cmd.burst > BURST_WIDTH'(1)) begin
                lock_d      = 1'b1;
                remaining_d = cmd.burst - 1'b1;
            end
        end
    end

    assign grant_update = !lock_d && (!request[grant_q] || accept) && (|request);
    assign grant_d      = grant_update ? winner : grant_q;

    // Read tracking: a burst count of zero, or no burst marker, means one beat.
    assign sel_new.id    = grant_q;
    assign sel_new.beats = (cmd.begin_burst && cmd.burst != '0) ? cmd.burst : BURST_WIDTH'(1);
    assign sel_push      = accept && out_read;
    assign sel_head      = sel_mem_q[sel_rd_q[SEL_AW-1:0]];

    // Beats arriving with nothing outstanding have no owner and are dropped.
    assign out_resp_ready = !resp_full;
    assign resp_push      = out_read_data_valid && !resp_full && !sel_empty;
    assign resp_pop       = !resp_empty && in_resp_ready[sel_head.id];
    assign sel_pop        = resp_pop && (beat_cnt_q == sel_head.beats - 1'b1);

    assign in_read_data = resp_empty ? '0 : resp_mem_q[resp_rd_q[RESP_AW-1:0]];

    always_comb begin
        in_read_data_valid = '0;
        if (!resp_empty) in_read_data_valid[sel_head.id] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            grant_q     <= '0;
            lock_q      <= 1'b0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            sel_wr_q    <= '0;
            sel_rd_q    <= '0;
            resp_wr_q   <= '0;
            resp_rd_q   <= '0;
        end else begin
            grant_q     <= grant_d;
            lock_q      <= lock_d;
            remaining_q <= remaining_d;
            if (sel_push)  sel_wr_q  <= sel_wr_q + 1'b1;
            if (sel_pop)   sel_rd_q  <= sel_rd_q + 1'b1;
            if (resp_push) resp_wr_q <= resp_wr_q + 1'b1;
            if (resp_pop)  resp_rd_q <= resp_rd_q + 1'b1;
            if (sel_pop)       beat_cnt_q <= '0;
            else if (resp_pop) beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (sel_push)  sel_mem_q[sel_wr_q[SEL_AW-1:0]]    <= sel_new;
        if (resp_push) resp_mem_q[resp_wr_q[RESP_AW-1:0]] <= out_read_data;
    end

endmodule

// File: tb/tb_avl_bus_n21_burst.sv
// -----------------------------------------------------------------------------
// tb_avl_bus_n21_burst
//   Random masters and a random-latency slave drive the interconnect. A
//   transaction-level reference model predicts the grant owner, the write-burst
//   lock, the occupancy of the tracking and response buffers, and the ordered
//   list of read beats each master must receive.
// -----------------------------------------------------------------------------
module tb_avl_bus_n21_burst;

    localparam int MN     = 4;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BW     = 4;
    localparam int ARB    = 1;
    localparam int SD     = 2;
    localparam int RD     = 4;
    localparam int BEW    = DW / 8;
    localparam int CYCLES = 3000;

    logic              clk = 1'b0;
    logic              rest;
    logic [MN*AW-1:0]  in_address;
    logic [MN*BEW-1:0] in_byte_en;
    logic [MN-1:0]     in_read, in_write, in_begin_burst_transfer;
    logic [MN*DW-1:0]  in_write_data;
    logic [MN*BW-1:0]  in_burst_count;
    logic [MN-1:0]     in_request_ready, in_read_data_valid, in_resp_ready;
    logic [DW-1:0]     in_read_data;
    logic [AW-1:0]     out_address;
    logic [BEW-1:0]    out_byte_en;
    logic              out_read, out_write, out_begin_burst_transfer;
    logic [DW-1:0]     out_write_data, out_read_data;
    logic [BW-1:0]     out_burst_count;
    logic              out_request_ready, out_read_data_valid, out_resp_ready;

    avl_bus_n21_burst #(
        .MASTER_NUM(MN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW),
        .ARB_METHOD(ARB), .SEL_FIFO_DEPTH(SD), .RESP_FIFO_DEPTH(RD)
    ) dut (
        .clk(clk), .rest(rest),
        .in_address(in_address), .in_byte_en(in_byte_en),
        .in_read(in_read), .in_write(in_write), .in_write_data(in_write_data),
        .in_begin_burst_transfer(in_begin_burst_transfer),
        .in_burst_count(in_burst_count), .in_request_ready(in_request_ready),
        .in_read_data(in_read_data), .in_read_data_valid(in_read_data_valid),
        .in_resp_ready(in_resp_ready),
        .out_address(out_address), .out_byte_en(out_byte_en),
        .out_read(out_read), .out_write(out_write),
        .out_write_data(out_write_data),
        .out_begin_burst_transfer(out_begin_burst_transfer),
        .out_burst_count(out_burst_count), .out_request_ready(out_request_ready),
        .out_read_data(out_read_data), .out_read_data_valid(out_read_data_valid),
        .out_resp_ready(out_resp_ready)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------- master behaviour
    typedef struct {
        bit             active;
        bit             is_rd;
        bit             begin_b;
        int             beats_left;
        logic [BW-1:0]  bc;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        logic [BEW-1:0] be;
    } mst_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        bit            last;
    } rsp_t;

    mst_t          mst [MN];
    rsp_t          exp_q [$];   // beats owed to masters, in delivery order
    logic [DW-1:0] slv_q [$];   // beats the slave still has to return
    int            sel_cnt, resp_cnt, exp_grant, exp_rem;
    bit            exp_lock;

    task automatic start_cmd(input int m);
        mst[m].active = 1'b1;
        mst[m].is_rd  = 1'($urandom_range(1));
        mst[m].addr   = $urandom;
        mst[m].data   = $urandom;
        mst[m].be     = BEW'($urandom);
        mst[m].beats_left = 1;
        if (mst[m].is_rd) begin
            mst[m].begin_b = 1'($urandom_range(1));
            mst[m].bc      = BW'($urandom_range(8));
        end else if ($urandom_range(99) < 30) begin
            mst[m].begin_b    = 1'b1;
            mst[m].bc         = BW'($urandom_range(5, 2));
            mst[m].beats_left = int'(mst[m].bc);
        end else begin
            mst[m].bc      = BW'($urandom_range(3));
            mst[m].begin_b = (mst[m].bc <= 1) ? 1'($urandom_range(1)) : 1'b0;
        end
    endtask

    task automatic on_accept(input int m);
        mst[m].beats_left--;
        if (mst[m].beats_left == 0) begin
            mst[m].active = 1'b0;
        end else begin
            mst[m].begin_b = 1'b0;
            mst[m].addr    = mst[m].addr + 4;
            mst[m].data    = $urandom;
        end
    endtask

    task automatic drive(input bit allow_new, input bit hold_resp);
        for (int m = 0; m < MN; m++) begin
            if (allow_new && !mst[m].active && $urandom_range(99) < 30) start_cmd(m);
            in_read[m]                 = mst[m].active && mst[m].is_rd;
            in_write[m]                = mst[m].active && !mst[m].is_rd;
            in_begin_burst_transfer[m] = mst[m].begin_b;
            in_burst_count[m*BW +: BW] = mst[m].bc;
            in_address[m*AW +: AW]     = mst[m].addr;
            in_write_data[m*DW +: DW]  = mst[m].data;
            in_byte_en[m*BEW +: BEW]   = mst[m].be;
            in_resp_ready[m]           = hold_resp ? 1'b0 : ($urandom_range(99) < 75);
        end
        out_request_ready   = ($urandom_range(99) < 70);
        out_read_data_valid = (slv_q.size() > 0) && ($urandom_range(99) < 70);
        out_read_data       = (slv_q.size() > 0) ? slv_q[0] : DW'($urandom);
    endtask

    function automatic int pick(input logic [MN-1:0] req, input int g);
        if (ARB == 0) begin
            for (int i = 0; i < MN; i++) if (req[i]) return i;
        end else begin
            for (int k = 1; k <= MN; k++) if (req[(g + k) % MN]) return (g + k) % MN;
        end
        return g;
    endfunction

    // --------------------------------------------------------- reference model
    task automatic step_model();
        int            g, rem_n, beats;
        logic          rd_g, wr_g, bg_g, e_out_read, acc, lock_n, resp_pushed;
        logic [BW-1:0] bc_g;
        logic [MN-1:0] e_irr, e_val, req;
        logic [DW-1:0] d;

        g          = exp_grant;
        rd_g       = in_read[g];
        wr_g       = in_write[g];
        bg_g       = in_begin_burst_transfer[g];
        bc_g       = in_burst_count[g*BW +: BW];
        e_out_read = rd_g && (sel_cnt < SD);

        check("cmd", {out_read, out_write, out_begin_burst_transfer, out_burst_count,
                      out_address, out_byte_en, out_write_data},
                     {e_out_read, wr_g, bg_g, bc_g, in_address[g*AW +: AW],
                      in_byte_en[g*BEW +: BEW], in_write_data[g*DW +: DW]});
        e_irr    = '0;
        e_irr[g] = out_request_ready && (wr_g || (sel_cnt < SD));
        check("req_ready", in_request_ready, e_irr);
        check("resp_ready", out_resp_ready, (resp_cnt < RD));
        e_val = '0;
        if (resp_cnt > 0) e_val[exp_q[0].id] = 1'b1;
        check("rd_valid", in_read_data_valid, e_val);
        if (resp_cnt > 0) check("rd_data", in_read_data, exp_q[0].data);

        acc = out_request_ready && (e_out_read || wr_g);

        // response buffer: push and pop both judged on pre-edge occupancy
        resp_pushed = out_read_data_valid && (resp_cnt < RD);
        if (resp_pushed) void'(slv_q.pop_front());
        if (resp_cnt > 0 && in_resp_ready[exp_q[0].id]) begin
            if (exp_q[0].last) sel_cnt--;
            void'(exp_q.pop_front());
            resp_cnt--;
        end
        if (resp_pushed) resp_cnt++;

        if (acc && e_out_read) begin
            beats = (bg_g && bc_g != 0) ? int'(bc_g) : 1;
            for (int b = 0; b < beats; b++) begin
                d = $urandom;
                slv_q.push_back(d);
                exp_q.push_back('{id: g, data: d, last: (b == beats - 1)});
            end
            sel_cnt++;
        end

        lock_n = exp_lock;
        rem_n  = exp_rem;
        if (acc && wr_g) begin
            if (exp_lock) begin
                rem_n--;
                if (rem_n == 0) lock_n = 1'b0;
            end else if (bg_g && bc_g > 1) begin
                lock_n = 1'b1;
                rem_n  = int'(bc_g) - 1;
            end
        end
        req = in_read | in_write;
        if (!lock_n && (!req[g] || acc) && req != '0) exp_grant = pick(req, g);
        exp_lock = lock_n;
        exp_rem  = rem_n;
        if (acc) on_accept(g);
    endtask

    // Asserts reset mid-cycle, checks the outputs react at once, then releases.
    task automatic reset_and_check(input string tag);
        rest = 1'b0;
        #1;
        check({tag, "_cmd"}, {out_read, out_write, out_begin_burst_transfer, out_burst_count,
                              out_address, out_byte_en, out_write_data}, '0);
        check({tag, "_req_ready"}, in_request_ready, '0);
        check({tag, "_resp_ready"}, out_resp_ready, 1'b1);
        check({tag, "_rd_valid"}, in_read_data_valid, '0);
        check({tag, "_rd_data"}, in_read_data, '0);
        for (int m = 0; m < MN; m++) begin
            mst[m].active  = 1'b0;
            mst[m].begin_b = 1'b0;
        end
        exp_q.delete();
        slv_q.delete();
        sel_cnt   = 0;
        resp_cnt  = 0;
        exp_grant = 0;
        exp_rem   = 0;
        exp_lock  = 1'b0;
        in_read             = '0;
        in_write            = '0;
        out_read_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rest = 1'b1;
    endtask

    // --------------------------------------------------------------- sequence
    initial begin
        bit mid_reset_done;
        int n_active;

        mid_reset_done = 1'b0;
        for (int m = 0; m < MN; m++) begin
            start_cmd(m);
        end
        in_read                 = '1;
        in_write                = '0;
        in_begin_burst_transfer = '1;
        in_burst_count          = {MN{BW'(3)}};
        in_address              = {MN{32'hDEAD_BEEF}};
        in_byte_en              = '1;
        in_write_data           = {MN{32'h1234_5678}};
        in_resp_ready           = '1;
        out_request_ready       = 1'b1;
        out_read_data_valid     = 1'b1;
        out_read_data           = 32'hA5A5_0000;
        reset_and_check("reset");

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            drive(1'b1, (cyc % 150) >= 100 && (cyc % 150) < 112);
            if (!mid_reset_done && cyc > 1500 && exp_lock) begin
                #1;
                reset_and_check("mid_reset");
                mid_reset_done = 1'b1;
            end else begin
                @(negedge clk);
                step_model();
            end
        end

        // Drain: no new commands; bounded so a stuck design still reaches the summary.
        for (int i = 0; i < 400; i++) begin
            n_active = 0;
            for (int m = 0; m < MN; m++) if (mst[m].active) n_active++;
            if (n_active == 0 && exp_q.size() == 0) break;
            @(posedge clk);
            #1;
            drive(1'b0, 1'b0);
            @(negedge clk);
            step_model();
        end
        n_active = 0;
        for (int m = 0; m < MN; m++) if (mst[m].active) n_active++;
        check("drain_masters_idle", n_active, 0);
        check("drain_beats_owed", exp_q.size(), 0);
        check("mid_reset_hit", mid_reset_done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
